// File: rtl/router_in_arbiter.sv
// Round-robin arbiter sharing the router's byte-wide input port among three packet sources.
// Holds the grant for a whole packet (header, payload, parity) and flags start timeouts and length mismatches.
module router_in_arbiter #(
    parameter int unsigned START_TIMEOUT = 16,
    parameter int unsigned TMR_W         = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [2:0]  src_pkt_valid,
    input  logic [23:0] src_data,
    input  logic        busy,
    output logic [2:0]  grant,
    output logic [2:0]  src_ready,
    output logic        pkt_valid,
    output logic [7:0]  data_in,
    output logic        timeout_err,
    output logic        len_err
);

    localparam int unsigned N_SRC = 3;
    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_HDR, XFER, GAP} state_t;

    state_t           state, state_nxt;
    logic [N_SRC-1:0] grant_nxt;
    logic [1:0]       rr_ptr, rr_ptr_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [CNT_W-1:0] byte_cnt, byte_cnt_nxt;
    logic [CNT_W-1:0] exp_len, exp_len_nxt;
    logic             timeout_err_nxt, len_err_nxt;
    logic             accept;
    logic             gsel_valid;
    logic [1:0]       cand1, cand2, pick;
    logic             pick_vld;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : 2'(i + 2'd1);
    endfunction

    // Search order rr_ptr+1, rr_ptr+2, rr_ptr so the last winner has lowest priority
    always_comb begin
        cand1    = next_idx(rr_ptr);
        cand2    = next_idx(cand1);
        pick     = rr_ptr;
        pick_vld = 1'b1;
        if (req[cand1])       pick = cand1;
        else if (req[cand2])  pick = cand2;
        else if (req[rr_ptr]) pick = rr_ptr;
        else                  pick_vld = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= 2'd2;
            timer       <= '0;
            byte_cnt    <= '0;
            exp_len     <= '0;
            timeout_err <= 1'b0;
            len_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            rr_ptr      <= rr_ptr_nxt;
            timer       <= timer_nxt;
            byte_cnt    <= byte_cnt_nxt;
            exp_len     <= exp_len_nxt;
            timeout_err <= timeout_err_nxt;
            len_err     <= len_err_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        grant_nxt       = grant;
        rr_ptr_nxt      = rr_ptr;
        timer_nxt       = timer;
        byte_cnt_nxt    = byte_cnt;
        exp_len_nxt     = exp_len;
        timeout_err_nxt = 1'b0;
        len_err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant_nxt  = N_SRC'(3'b001 << pick);
                    rr_ptr_nxt = pick;
                    timer_nxt  = '0;
                    state_nxt  = WAIT_HDR;
                end
            end
            WAIT_HDR: begin
                if (accept) begin
                    exp_len_nxt  = data_in[7:2];
                    byte_cnt_nxt = '0;
                    state_nxt    = XFER;
                end else if (timer == TMR_LAST) begin
                    grant_nxt       = '0;
                    timeout_err_nxt = 1'b1;
                    state_nxt       = GAP;
                end else begin
                    timer_nxt = TMR_W'(timer + 1'b1);
                end
            end
            XFER: begin
                if (accept) begin
                    if (pkt_valid) begin
                        if (byte_cnt != CNT_MAX) byte_cnt_nxt = CNT_W'(byte_cnt + 1'b1);
                    end else begin
                        len_err_nxt = (byte_cnt != exp_len);
                        grant_nxt   = '0;
                        state_nxt   = GAP;
                    end
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Port mux and back-pressure toward the granted source
    always_comb begin
        data_in    = '0;
        pkt_valid  = 1'b0;
        src_ready  = '0;
        gsel_valid = |(grant & src_pkt_valid);
        case (grant)
            3'b001:  data_in = src_data[7:0];
            3'b010:  data_in = src_data[15:8];
            3'b100:  data_in = src_data[23:16];
            default: data_in = '0;
        endcase
        case (state)
            WAIT_HDR: begin
                pkt_valid = gsel_valid;
                if (gsel_valid) src_ready = grant & {N_SRC{~busy}};
            end
            XFER: begin
                pkt_valid = gsel_valid;
                src_ready = grant & {N_SRC{~busy}};
            end
            default: ;
        endcase
    end

    assign accept = |src_ready;

endmodule

// File: tb/tb_router_in_arbiter.sv
// Bench for router_in_arbiter: modelled packet sources, directed scenarios and a randomized
// run checked against a packet-level reference (round-robin order, byte stream, length errors).
module tb_router_in_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = '0;
    logic [2:0]  src_pkt_valid = '0;
    logic [23:0] src_data = '0;
    logic        busy = 1'b0;
    logic [2:0]  grant, src_ready;
    logic        pkt_valid, timeout_err, len_err;
    logic [7:0]  data_in;

    router_in_arbiter #(.START_TIMEOUT(16), .TMR_W(5)) dut (
        .clk(clk), .reset(reset), .req(req), .src_pkt_valid(src_pkt_valid),
        .src_data(src_data), .busy(busy), .grant(grant), .src_ready(src_ready),
        .pkt_valid(pkt_valid), .data_in(data_in), .timeout_err(timeout_err), .len_err(len_err)
    );

    always #5 clk = ~clk;

    // Source-side byte queues (what each source still has to present)
    logic [7:0] sq [3][$];
    bit         sv [3][$];
    bit         hold [3];
    // Reference copies of what the router must receive, plus expected len_err per packet
    logic [7:0] eq [3][$];
    bit         evq [3][$];
    bit         ele [3][$];
    bit         busy_force, rand_busy;

    logic [2:0] o_grant, o_rdy, o_req;
    logic       o_pv, o_te, o_le, o_busy;
    logic [7:0] o_data;
    int         n_cmp = 0, n_bad = 0;

    task automatic drive();
        for (int n = 0; n < 3; n++) begin
            req[n] = 1'b0; src_pkt_valid[n] = 1'b0; src_data[8*n +: 8] = 8'h00;
            if (sq[n].size() != 0) begin
                req[n] = 1'b1;
                src_pkt_valid[n] = sv[n][0] && !hold[n];
                src_data[8*n +: 8] = sq[n][0];
            end
        end
        busy = rand_busy ? ($urandom_range(0, 3) == 0) : busy_force;
    endtask

    task automatic clear_srcs();
        for (int n = 0; n < 3; n++) begin
            sq[n].delete(); sv[n].delete(); eq[n].delete(); evq[n].delete(); ele[n].delete();
            hold[n] = 1'b0;
        end
    endtask

    task automatic push_pkt(input int n, input logic [7:0] hdr, input int npay, input bit rnd);
        logic [7:0] b, par;
        int sat;
        par = hdr;
        sq[n].push_back(hdr); sv[n].push_back(1'b1); eq[n].push_back(hdr); evq[n].push_back(1'b1);
        for (int k = 0; k < npay; k++) begin
            b = rnd ? 8'($urandom) : 8'(8'hA0 + k);
            sq[n].push_back(b); sv[n].push_back(1'b1); eq[n].push_back(b); evq[n].push_back(1'b1);
            par ^= b;
        end
        sq[n].push_back(par); sv[n].push_back(1'b0); eq[n].push_back(par); evq[n].push_back(1'b0);
        sat = (npay > 63) ? 63 : npay;
        ele[n].push_back(sat != int'(hdr[7:2]));
    endtask

    // Sample away from the active edge, then let sources advance on what was accepted
    task automatic tick();
        @(negedge clk);
        o_grant = grant; o_rdy = src_ready; o_pv = pkt_valid; o_data = data_in;
        o_te = timeout_err; o_le = len_err; o_req = req; o_busy = busy;
        @(posedge clk);
        #1;
        for (int n = 0; n < 3; n++)
            if (o_rdy[n] && sq[n].size() != 0) begin sq[n].delete(0); sv[n].delete(0); end
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1; clear_srcs(); busy_force = 1'b0; rand_busy = 1'b0; drive();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear_srcs(); drive();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (grant !== 3'b000) begin n_bad++; $display("FAIL reset_grant: got %b want 000", grant); end
        n_cmp++; if (src_ready !== 3'b000) begin n_bad++; $display("FAIL reset_ready: got %b want 000", src_ready); end
        n_cmp++; if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_pv: got %b want 0", pkt_valid); end
        n_cmp++; if (data_in !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", data_in); end
        n_cmp++; if (timeout_err !== 1'b0 || len_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_errs: got te=%b le=%b want 0 0", timeout_err, len_err); end
        reset = 1'b0;
        tick();
        n_cmp++; if (o_grant !== 3'b000) begin n_bad++; $display("FAIL idle_noreq: got %b want 000", o_grant); end
    endtask

    task automatic test_single();
        logic [2:0] eg [8] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
        logic [7:0] ed [8] = '{8'h00, 8'h0D, 8'hA0, 8'hA1, 8'hA2, 8'h0D ^ 8'hA0 ^ 8'hA1 ^ 8'hA2, 8'h00, 8'h00};
        logic       ep [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        push_pkt(0, 8'h0D, 3, 1'b0);
        drive();
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++; if (o_grant !== eg[i]) begin n_bad++; $display("FAIL single_grant[%0d]: got %b want %b", i, o_grant, eg[i]); end
            n_cmp++; if (o_rdy !== eg[i]) begin n_bad++; $display("FAIL single_ready[%0d]: got %b want %b", i, o_rdy, eg[i]); end
            n_cmp++; if (o_data !== ed[i]) begin n_bad++; $display("FAIL single_data[%0d]: got %h want %h", i, o_data, ed[i]); end
            n_cmp++; if (o_pv !== ep[i]) begin n_bad++; $display("FAIL single_pv[%0d]: got %b want %b", i, o_pv, ep[i]); end
            n_cmp++; if (o_le !== 1'b0) begin n_bad++; $display("FAIL single_lenerr[%0d]: got %b want 0", i, o_le); end
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        logic [2:0] prev = '0;
        int ng = 0, zr = 0;
        do_reset();
        push_pkt(0, 8'h04, 1, 1'b0); push_pkt(1, 8'h05, 1, 1'b0);
        push_pkt(2, 8'h07, 1, 1'b0); push_pkt(0, 8'h06, 1, 1'b0);
        drive();
        for (int t = 0; t < 60 && ng < 4; t++) begin
            tick();
            if (o_grant != 3'b000 && prev == 3'b000) begin
                n_cmp++; if (o_grant !== exp_seq[ng]) begin
                    n_bad++; $display("FAIL rr_order[%0d]: got %b want %b", ng, o_grant, exp_seq[ng]); end
                if (ng > 0) begin
                    n_cmp++; if (zr != 2) begin n_bad++; $display("FAIL rr_gap[%0d]: got %0d want 2", ng, zr); end
                end
                ng++;
            end
            zr = (o_grant == 3'b000) ? zr + 1 : 0;
            prev = o_grant;
        end
        n_cmp++; if (ng != 4) begin n_bad++; $display("FAIL rr_count: got %0d want 4", ng); end
    endtask

    task automatic test_busy_stall();
        int acc = 0;
        bit ended = 0;
        do_reset();
        push_pkt(0, 8'h10, 4, 1'b0);
        drive();
        repeat (3) begin tick(); if (o_rdy != 3'b000) acc++; end
        busy_force = 1'b1; drive();
        for (int i = 0; i < 4; i++) begin
            tick(); if (o_rdy != 3'b000) acc++;
            n_cmp++; if (o_rdy !== 3'b000) begin n_bad++; $display("FAIL stall_ready[%0d]: got %b want 000", i, o_rdy); end
            n_cmp++; if (o_data !== 8'hA1) begin n_bad++; $display("FAIL stall_data[%0d]: got %h want a1", i, o_data); end
            n_cmp++; if (o_grant !== 3'b001) begin n_bad++; $display("FAIL stall_grant[%0d]: got %b want 001", i, o_grant); end
        end
        busy_force = 1'b0; drive();
        for (int t = 0; t < 20 && !ended; t++) begin
            tick(); if (o_rdy != 3'b000) acc++;
            if (o_grant == 3'b000) ended = 1;
        end
        n_cmp++; if (!ended) begin n_bad++; $display("FAIL stall_end: got grant %b want 000", o_grant); end
        n_cmp++; if (acc != 6) begin n_bad++; $display("FAIL stall_bytes: got %0d want 6", acc); end
        n_cmp++; if (o_le !== 1'b0) begin n_bad++; $display("FAIL stall_lenerr: got %b want 0", o_le); end
    endtask

    task automatic test_len_err();
        bit found = 0;
        do_reset();
        push_pkt(0, 8'h10, 2, 1'b0);
        drive();
        for (int t = 0; t < 20 && !found; t++) begin
            tick();
            if (o_rdy != 3'b000 && !o_pv) found = 1;
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL lenerr_parity: got no parity accept want one"); end
        n_cmp++; if (o_le !== 1'b0) begin n_bad++; $display("FAIL lenerr_early: got %b want 0", o_le); end
        tick();
        n_cmp++; if (o_le !== 1'b1) begin n_bad++; $display("FAIL lenerr_pulse: got %b want 1", o_le); end
        n_cmp++; if (o_grant !== 3'b000) begin n_bad++; $display("FAIL lenerr_grant: got %b want 000", o_grant); end
        tick();
        n_cmp++; if (o_le !== 1'b0) begin n_bad++; $display("FAIL lenerr_once: got %b want 0", o_le); end
    endtask

    task automatic test_timeout();
        do_reset();
        push_pkt(1, 8'h08, 2, 1'b0); hold[1] = 1'b1;
        push_pkt(2, 8'h04, 1, 1'b0);
        drive();
        tick();
        tick();
        n_cmp++; if (o_grant !== 3'b010) begin n_bad++; $display("FAIL to_grant: got %b want 010", o_grant); end
        for (int i = 2; i <= 16; i++) begin
            tick();
            n_cmp++; if (o_te !== 1'b0 || o_grant !== 3'b010) begin
                n_bad++; $display("FAIL to_early[%0d]: got te=%b grant=%b want 0 010", i, o_te, o_grant); end
        end
        tick();
        n_cmp++; if (o_te !== 1'b1) begin n_bad++; $display("FAIL to_pulse: got %b want 1", o_te); end
        n_cmp++; if (o_grant !== 3'b000) begin n_bad++; $display("FAIL to_revoke: got %b want 000", o_grant); end
        sq[1].delete(); sv[1].delete(); hold[1] = 1'b0; drive();
        tick();
        n_cmp++; if (o_te !== 1'b0) begin n_bad++; $display("FAIL to_once: got %b want 0", o_te); end
        tick();
        n_cmp++; if (o_grant !== 3'b100) begin n_bad++; $display("FAIL to_next: got %b want 100", o_grant); end
    endtask

    task automatic test_async_reset();
        do_reset();
        push_pkt(0, 8'h0C, 3, 1'b0);
        drive();
        repeat (3) tick();
        n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL ar_pre: got %b want 001", grant); end
        reset = 1'b1;
        #1;
        n_cmp++; if (grant !== 3'b000 || pkt_valid !== 1'b0 || src_ready !== 3'b000) begin
            n_bad++; $display("FAIL ar_now: got g=%b pv=%b rdy=%b want 000 0 000", grant, pkt_valid, src_ready); end
        clear_srcs();
        push_pkt(0, 8'h04, 1, 1'b0); push_pkt(1, 8'h04, 1, 1'b0); push_pkt(2, 8'h04, 1, 1'b0);
        drive();
        #1 reset = 1'b0;
        tick();
        tick();
        n_cmp++; if (o_grant !== 3'b001) begin n_bad++; $display("FAIL ar_first: got %b want 001", o_grant); end
    endtask

    task automatic test_random();
        int last = 2, zr = 0, g, pick, idx;
        bit seen = 0, le_pend = 0, le_exp = 0, done = 0, eb_v, exp_le;
        logic [2:0] prev_g = '0, prev_req = '0, exp_g;
        logic [7:0] eb;
        do_reset();
        for (int n = 0; n < 3; n++)
            for (int p = 0; p < 5; p++) begin
                int len = $urandom_range(0, 6);
                int npay = len;
                if ($urandom_range(0, 3) == 0) npay = (len == 0 || $urandom_range(0, 1) == 1) ? len + 1 : len - 1;
                push_pkt(n, {6'(len), 2'($urandom_range(0, 3))}, npay, 1'b1);
            end
        rand_busy = 1'b1; drive();
        for (int t = 0; t < 3000 && !done; t++) begin
            tick();
            exp_le = le_pend ? le_exp : 1'b0;
            le_pend = 0;
            n_cmp++; if (o_le !== exp_le) begin n_bad++; $display("FAIL rnd_lenerr@%0d: got %b want %b", t, o_le, exp_le); end
            n_cmp++; if (o_te !== 1'b0) begin n_bad++; $display("FAIL rnd_timeout@%0d: got %b want 0", t, o_te); end
            if (o_grant != 3'b000 && prev_g == 3'b000) begin
                pick = -1;
                for (int k = 1; k <= 3; k++) begin
                    idx = (last + k) % 3;
                    if (pick < 0 && prev_req[2'(idx)]) pick = idx;
                end
                exp_g = (pick < 0) ? 3'b000 : 3'(1 << pick);
                n_cmp++; if (o_grant !== exp_g) begin n_bad++; $display("FAIL rnd_arb@%0d: got %b want %b", t, o_grant, exp_g); end
                if (seen) begin
                    n_cmp++; if (zr != 2) begin n_bad++; $display("FAIL rnd_gap@%0d: got %0d want 2", t, zr); end
                end
                seen = 1;
                if (pick >= 0) last = pick;
            end else if (o_grant != 3'b000) begin
                n_cmp++; if (o_grant !== prev_g) begin n_bad++; $display("FAIL rnd_hold@%0d: got %b want %b", t, o_grant, prev_g); end
            end
            if (o_rdy != 3'b000) begin
                n_cmp++; if (o_rdy !== o_grant || o_busy !== 1'b0) begin
                    n_bad++; $display("FAIL rnd_ready@%0d: got rdy=%b busy=%b want rdy=%b busy=0", t, o_rdy, o_busy, o_grant); end
                g = (o_grant == 3'b001) ? 0 : (o_grant == 3'b010) ? 1 : (o_grant == 3'b100) ? 2 : -1;
                if (g >= 0) begin
                    n_cmp++;
                    if (eq[g].size() == 0) begin
                        n_bad++; $display("FAIL rnd_extra@%0d: got byte %h want none", t, o_data);
                    end else begin
                        eb = eq[g].pop_front(); eb_v = evq[g].pop_front();
                        if (o_data !== eb || o_pv !== eb_v) begin
                            n_bad++; $display("FAIL rnd_byte@%0d: got %h/%b want %h/%b", t, o_data, o_pv, eb, eb_v); end
                        if (!eb_v) begin le_pend = 1; le_exp = ele[g].pop_front(); end
                    end
                end
            end
            zr = (o_grant == 3'b000) ? zr + 1 : 0;
            prev_g = o_grant; prev_req = o_req;
            done = (eq[0].size() == 0 && eq[1].size() == 0 && eq[2].size() == 0 && o_grant == 3'b000 && !le_pend);
        end
        rand_busy = 1'b0; drive();
        n_cmp++; if (!done) begin n_bad++; $display("FAIL rnd_complete: got %0d/%0d/%0d bytes left want 0", eq[0].size(), eq[1].size(), eq[2].size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_busy_stall();
        test_len_err();
        test_timeout();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
